bram_port_arbiter: RTL and testbench



---
 rtl/bram_port_arbiter.sv | 116 +++++++++++
 tb/tb_bram_port_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter that shares port A of the CNN buffer RAM among NREQ
// requesters. One access is granted per cycle, the RAM port is driven from
// registers, and read data is routed back through a one-hot tag pipeline.
module bram_port_arbiter #(
   parameter int NREQ   = 3,
   parameter int AW     = 5,
   parameter int DW     = 16,
   parameter int RD_LAT = 2
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ-1:0]      req_we,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*DW-1:0]   req_wdata,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [DW-1:0]        rsp_data,
   output logic [AW-1:0]        mem_address,
   output logic [DW-1:0]        mem_data,
   output logic                 mem_wren,
   output logic                 mem_rden,
   input  logic [DW-1:0]        mem_q
);

   localparam int PW = $clog2(NREQ);

   logic [PW-1:0]   rr_ptr_reg;
   logic [PW-1:0]   win_idx;
   logic            win_found;
   logic            hs;
   logic [AW-1:0]   addr_arr [NREQ];
   logic [DW-1:0]   wdata_arr [NREQ];
   logic [AW-1:0]   mem_address_reg;
   logic [DW-1:0]   mem_data_reg;
   logic            mem_wren_reg;
   logic            mem_rden_reg;
   // Stage 0 is loaded at the handshake edge; stage RD_LAT lines up with mem_q.
   logic [NREQ-1:0] tag_reg [RD_LAT+1];

   // (base + off) mod NREQ, for off in 0..NREQ
   function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NREQ) s = s - NREQ;
      return PW'(s);
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_req
         assign addr_arr[gi]  = req_addr[gi*AW +: AW];
         assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
         // Held low during reset so no grant is visible while reset_n is asserted
         assign req_ready[gi] = reset_n & win_found & (win_idx == PW'(gi));
      end
   endgenerate

   assign hs = |req_ready;

   // Pick the first valid requester at or above rr_ptr, wrapping modulo NREQ
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!win_found && req_valid[wrap_add(rr_ptr_reg, k)]) begin
            win_found = 1'b1;
            win_idx   = wrap_add(rr_ptr_reg, k);
         end
      end
   end

   // Priority pointer moves just past the requester that completed a handshake
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr_reg <= '0;
      end else if (hs) begin
         rr_ptr_reg <= wrap_add(win_idx, 1);
      end
   end

   // Registered issue stage; address/data hold when no access is granted
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mem_address_reg <= '0;
         mem_data_reg    <= '0;
         mem_wren_reg    <= 1'b0;
         mem_rden_reg    <= 1'b0;
      end else begin
         mem_wren_reg <= hs & req_we[win_idx];
         mem_rden_reg <= hs & ~req_we[win_idx];
         if (hs) begin
            mem_address_reg <= addr_arr[win_idx];
            mem_data_reg    <= wdata_arr[win_idx];
         end
      end
   end

   // Tag shift register: one-hot requester id for reads, zero otherwise
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s <= RD_LAT; s++) tag_reg[s] <= '0;
      end else begin
         tag_reg[0] <= (hs && !req_we[win_idx]) ? req_ready : '0;
         for (int s = 1; s <= RD_LAT; s++) tag_reg[s] <= tag_reg[s-1];
      end
   end

   assign mem_address = mem_address_reg;
   assign mem_data    = mem_data_reg;
   assign mem_wren    = mem_wren_reg;
   assign mem_rden    = mem_rden_reg;
   assign rsp_valid   = tag_reg[RD_LAT];
   assign rsp_data    = mem_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a small RD_LAT=2 RAM model on port A.
module tb_bram_port_arbiter;

   logic        clock;
   logic        reset_n;
   logic [2:0]  req_valid;
   logic [2:0]  req_ready;
   logic [2:0]  req_we;
   logic [14:0] req_addr;
   logic [47:0] req_wdata;
   logic [2:0]  rsp_valid;
   logic [15:0] rsp_data;
   logic [4:0]  mem_address;
   logic [15:0] mem_data;
   logic        mem_wren;
   logic        mem_rden;
   logic [15:0] mem_q;

   int checks   = 0;
   int failures = 0;

   bram_port_arbiter #(.NREQ(3), .AW(5), .DW(16), .RD_LAT(2)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_data   (rsp_data),
      .mem_address(mem_address),
      .mem_data   (mem_data),
      .mem_wren   (mem_wren),
      .mem_rden   (mem_rden),
      .mem_q      (mem_q)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // RAM model: write and read sampled at the same edge (read returns old data),
   // q valid two cycles after the sampling edge of mem_rden
   logic [15:0] ram [32];
   logic [15:0] q1, q2;
   always @(posedge clock) begin
      if (mem_wren) ram[mem_address] <= mem_data;
      if (mem_rden) q1 <= ram[mem_address];
      q2 <= q1;
   end
   assign mem_q = q2;

   // One line per transaction
   always @(posedge clock) begin
      if (reset_n && |(req_valid & req_ready))
         $display("[%0t] grant ready=%b we=%b", $time, req_ready, |(req_we & req_ready));
      if (reset_n && |rsp_valid)
         $display("[%0t] response rsp_valid=%b data=%h", $time, rsp_valid, rsp_data);
   end

   task automatic test_reset();
      reset_n   = 1'b0;
      req_valid = 3'b111;
      req_we    = 3'b000;
      req_addr  = '0;
      req_wdata = '0;
      repeat (3) @(negedge clock);
      checks++; if (req_ready !== 3'b000) begin failures++; $display("FAIL reset_ready got %b expected 000", req_ready); end
      checks++; if (mem_wren !== 1'b0) begin failures++; $display("FAIL reset_wren got %b expected 0", mem_wren); end
      checks++; if (mem_rden !== 1'b0) begin failures++; $display("FAIL reset_rden got %b expected 0", mem_rden); end
      checks++; if (rsp_valid !== 3'b000) begin failures++; $display("FAIL reset_rsp got %b expected 000", rsp_valid); end
      checks++; if (mem_address !== 5'd0) begin failures++; $display("FAIL reset_addr got %0d expected 0", mem_address); end
      checks++; if (mem_data !== 16'h0000) begin failures++; $display("FAIL reset_data got %h expected 0000", mem_data); end
      reset_n = 1'b1;
      #1;
      checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL first_grant got %b expected 001", req_ready); end
      req_valid = 3'b000;
      @(negedge clock);
   endtask

   task automatic test_write_read();
      req_valid = 3'b001; req_we = 3'b001;
      req_addr[0 +: 5] = 5'd5; req_wdata[0 +: 16] = 16'hBEEF;
      #1;
      checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL wr_ready got %b expected 001", req_ready); end
      @(negedge clock);
      checks++; if (mem_wren !== 1'b1 || mem_rden !== 1'b0) begin failures++; $display("FAIL wr_strobe got wren=%b rden=%b expected 1/0", mem_wren, mem_rden); end
      checks++; if (mem_address !== 5'd5) begin failures++; $display("FAIL wr_addr got %0d expected 5", mem_address); end
      checks++; if (mem_data !== 16'hBEEF) begin failures++; $display("FAIL wr_data got %h expected beef", mem_data); end
      req_we = 3'b000;
      #1;
      checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL rd_ready got %b expected 001", req_ready); end
      @(negedge clock);
      req_valid = 3'b000;
      checks++; if (mem_rden !== 1'b1 || mem_wren !== 1'b0) begin failures++; $display("FAIL rd_strobe got rden=%b wren=%b expected 1/0", mem_rden, mem_wren); end
      checks++; if (mem_address !== 5'd5) begin failures++; $display("FAIL rd_addr got %0d expected 5", mem_address); end
      @(negedge clock);
      checks++; if (rsp_valid !== 3'b000) begin failures++; $display("FAIL rd_early got %b expected 000", rsp_valid); end
      checks++; if (mem_rden !== 1'b0 || mem_wren !== 1'b0) begin failures++; $display("FAIL idle_strobe got rden=%b wren=%b expected 0/0", mem_rden, mem_wren); end
      @(negedge clock);
      checks++; if (rsp_valid !== 3'b001) begin failures++; $display("FAIL rd_rsp got %b expected 001", rsp_valid); end
      checks++; if (rsp_data !== 16'hBEEF) begin failures++; $display("FAIL rd_rsp_data got %h expected beef", rsp_data); end
      @(negedge clock);
      checks++; if (rsp_valid !== 3'b000) begin failures++; $display("FAIL rd_rsp_1cyc got %b expected 000", rsp_valid); end
   endtask

   task automatic test_fairness();
      logic [2:0] exp_ready;
      int         exp_idx;
      req_we = 3'b111;
      req_addr  = {5'd22, 5'd21, 5'd20};
      req_wdata = {16'h0C02, 16'h0C01, 16'h0C00};
      // pointer is 1 here; a grant to requester 2 brings it back to 0
      req_valid = 3'b100;
      #1;
      checks++; if (req_ready !== 3'b100) begin failures++; $display("FAIL steer_ready got %b expected 100", req_ready); end
      @(negedge clock);
      req_valid = 3'b111;
      for (int c = 0; c < 9; c++) begin
         exp_idx   = c % 3;
         exp_ready = 3'(1 << exp_idx);
         #1;
         checks++; if (req_ready !== exp_ready) begin failures++; $display("FAIL rr3_ready[%0d] got %b expected %b", c, req_ready, exp_ready); end
         @(negedge clock);
         checks++; if (mem_address !== 5'(20 + exp_idx) || mem_wren !== 1'b1) begin failures++; $display("FAIL rr3_issue[%0d] got addr=%0d wren=%b expected %0d/1", c, mem_address, mem_wren, 20 + exp_idx); end
      end
      req_valid = 3'b101;
      for (int c = 0; c < 4; c++) begin
         exp_idx   = (c % 2) * 2;
         exp_ready = 3'(1 << exp_idx);
         #1;
         checks++; if (req_ready !== exp_ready) begin failures++; $display("FAIL rr2_ready[%0d] got %b expected %b", c, req_ready, exp_ready); end
         @(negedge clock);
      end
      req_valid = 3'b000;
      @(negedge clock);
   endtask

   task automatic test_pipelined_reads();
      // preload addr 31 and addr 0 (pointer is 0)
      req_we = 3'b110;
      req_addr[5 +: 5] = 5'd31; req_wdata[16 +: 16] = 16'h1111;
      req_addr[10 +: 5] = 5'd0; req_wdata[32 +: 16] = 16'h2222;
      req_valid = 3'b110;
      #1;
      checks++; if (req_ready !== 3'b010) begin failures++; $display("FAIL pre1_ready got %b expected 010", req_ready); end
      @(negedge clock);
      req_valid = 3'b100;
      #1;
      checks++; if (req_ready !== 3'b100) begin failures++; $display("FAIL pre2_ready got %b expected 100", req_ready); end
      @(negedge clock);
      req_valid = 3'b000;
      @(negedge clock);
      // back-to-back reads from requesters 1 and 2 (pointer is 0)
      req_we = 3'b000;
      req_valid = 3'b110;
      #1;
      checks++; if (req_ready !== 3'b010) begin failures++; $display("FAIL prd1_ready got %b expected 010", req_ready); end
      @(negedge clock);
      checks++; if (mem_address !== 5'd31 || mem_rden !== 1'b1) begin failures++; $display("FAIL prd1_issue got addr=%0d rden=%b expected 31/1", mem_address, mem_rden); end
      req_valid = 3'b100;
      #1;
      checks++; if (req_ready !== 3'b100) begin failures++; $display("FAIL prd2_ready got %b expected 100", req_ready); end
      @(negedge clock);
      checks++; if (mem_address !== 5'd0 || mem_rden !== 1'b1) begin failures++; $display("FAIL prd2_issue got addr=%0d rden=%b expected 0/1", mem_address, mem_rden); end
      req_valid = 3'b000;
      @(negedge clock);
      checks++; if (rsp_valid !== 3'b010) begin failures++; $display("FAIL prd1_rsp got %b expected 010", rsp_valid); end
      checks++; if (rsp_data !== 16'h1111) begin failures++; $display("FAIL prd1_data got %h expected 1111", rsp_data); end
      @(negedge clock);
      checks++; if (rsp_valid !== 3'b100) begin failures++; $display("FAIL prd2_rsp got %b expected 100", rsp_valid); end
      checks++; if (rsp_data !== 16'h2222) begin failures++; $display("FAIL prd2_data got %h expected 2222", rsp_data); end
      @(negedge clock);
   endtask

   task automatic test_hazard();
      // requester 0 seeds addr 7 with old data and moves the pointer to 1
      req_we = 3'b011;
      req_addr  = {5'd7, 5'd7, 5'd7};
      req_wdata = {16'h0000, 16'h00AA, 16'h5555};
      req_valid = 3'b001;
      #1;
      checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL hz_seed_ready got %b expected 001", req_ready); end
      @(negedge clock);
      req_valid = 3'b110;
      #1;
      checks++; if (req_ready !== 3'b010) begin failures++; $display("FAIL hz_wr_ready got %b expected 010", req_ready); end
      @(negedge clock);
      req_valid = 3'b100;
      #1;
      checks++; if (req_ready !== 3'b100) begin failures++; $display("FAIL hz_rd_ready got %b expected 100", req_ready); end
      @(negedge clock);
      req_valid = 3'b000;
      @(negedge clock);
      checks++; if (rsp_valid !== 3'b000) begin failures++; $display("FAIL hz_early got %b expected 000", rsp_valid); end
      @(negedge clock);
      checks++; if (rsp_valid !== 3'b100) begin failures++; $display("FAIL hz_rsp got %b expected 100", rsp_valid); end
      checks++; if (rsp_data !== 16'h00AA) begin failures++; $display("FAIL hz_data got %h expected 00aa", rsp_data); end
      @(negedge clock);
   endtask

   task automatic test_reset_midflight();
      int seen;
      seen = 0;
      // pointer is 0; requester 0 reads, then reset hits before the response
      req_we = 3'b000;
      req_addr[0 +: 5] = 5'd5;
      req_valid = 3'b001;
      #1;
      checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL mr_ready got %b expected 001", req_ready); end
      @(negedge clock);
      req_valid = 3'b000;
      reset_n   = 1'b0;
      #1;
      checks++; if (mem_rden !== 1'b0) begin failures++; $display("FAIL mr_rden_clr got %b expected 0", mem_rden); end
      @(negedge clock);
      reset_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (rsp_valid !== 3'b000) seen++;
         @(negedge clock);
      end
      checks++; if (seen !== 0) begin failures++; $display("FAIL mr_no_rsp got %0d responses expected 0", seen); end
      req_valid = 3'b111;
      #1;
      checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL mr_ptr got %b expected 001", req_ready); end
      req_valid = 3'b000;
      @(negedge clock);
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_fairness();
      test_pipelined_reads();
      test_hazard();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
